execute_upwards_mix_array_streamer: RTL and testbench

//  Read-side drain stage for the mix_array_2 dual-port RAM. Sequences reads on RAM port 1 over a window
//  [base, base+len), absorbs the 1-cycle RAM read latency and emits the words as a valid/ready stream

---
 rtl/execute_upwards_mix_pkg.sv | 12 +
 rtl/execute_upwards_mix_fifo2.sv | 44 ++++
 rtl/execute_upwards_new_bro_node_mix_array_2.sv | 29 ++
 rtl/execute_upwards_mix_array_streamer.sv | 93 +++++++++
 tb/tb_execute_upwards_mix_array_streamer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/execute_upwards_mix_pkg.sv
// Shared types and helpers for the mix_array read-side streamer.
package execute_upwards_mix_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int FIFO_DEPTH = 2;

    function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned range);
        return (addr + 1 == range) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/execute_upwards_mix_fifo2.sv
// Two-entry synchronous FIFO holding {last, data} beats for the streamer.
module execute_upwards_mix_fifo2
    import execute_upwards_mix_pkg::*;
#(
    parameter int Width = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] dout,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);
    logic [Width-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr, rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // The upstream credit rule must keep this from ever firing.
    always @(posedge clk) begin
        if (!reset) assert (!(push && full && !pop));
    end
endmodule

// File: rtl/execute_upwards_new_bro_node_mix_array_2.sv
// Dual-port RAM: port 0 read/write, port 1 read-only, one-cycle registered read.
module execute_upwards_new_bro_node_mix_array_2 #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5,
    parameter int AddressRange = 32
) (
    input  logic                    clk,
    input  logic [AddressWidth-1:0] address0,
    input  logic                    ce0,
    input  logic                    we0,
    input  logic [DataWidth-1:0]    d0,
    output logic [DataWidth-1:0]    q0,
    input  logic [AddressWidth-1:0] address1,
    input  logic                    ce1,
    output logic [DataWidth-1:0]    q1
);
    logic [DataWidth-1:0] ram [AddressRange];

    always_ff @(posedge clk) begin
        if (ce0) begin
            if (we0) ram[address0] <= d0;
            q0 <= ram[address0];
        end
    end

    always_ff @(posedge clk) begin
        if (ce1) q1 <= ram[address1];
    end
endmodule

// File: rtl/execute_upwards_mix_array_streamer.sv
// Reads a [base, base+len) window from RAM port 1 and emits it as a valid/ready stream.
module execute_upwards_mix_array_streamer
    import execute_upwards_mix_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5,
    parameter int AddressRange = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AddressWidth-1:0] base,
    input  logic [AddressWidth:0]   len,
    output logic                    busy,
    output logic                    done,
    output logic [AddressWidth-1:0] address1,
    output logic                    ce1,
    input  logic [DataWidth-1:0]    q1,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);
    state_t                state;
    logic [AddressWidth:0] len_r, issued;
    logic                  inflight, inflight_last;
    logic                  issue, pop, fifo_empty, fifo_full;
    logic [1:0]            fifo_count;
    logic [DataWidth:0]    fifo_dout;

    assign pop = out_valid & out_ready;
    // Stored + in-flight beats, less the one leaving now, must stay below the FIFO depth.
    assign issue = (state == S_RUN) && (issued != len_r) &&
                   (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    assign ce1       = issue;
    assign out_valid = !fifo_empty;
    assign out_last  = fifo_dout[DataWidth];
    assign out_data  = fifo_dout[DataWidth-1:0];

    execute_upwards_mix_fifo2 #(.Width(DataWidth + 1)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .din   ({inflight_last, q1}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            len_r         <= '0;
            issued        <= '0;
            address1      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                inflight_last <= ((issued + (AddressWidth+1)'(1)) == len_r);
                issued        <= issued + (AddressWidth+1)'(1);
                address1      <= AddressWidth'(wrap_inc(int'(address1), AddressRange));
            end
            case (state)
                S_IDLE: if (start) begin
                    len_r    <= len;
                    issued   <= '0;
                    address1 <= base;
                    if (len == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: if (pop && out_last) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_execute_upwards_mix_array_streamer.sv
// Directed, table-driven bench for the streamer against the real dual-port RAM model.
module tb_execute_upwards_mix_array_streamer;
    localparam int DW = 32, AW = 5, AR = 32;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, ce1, out_valid, out_last;
    logic          out_ready = 1'b0;
    logic [AW-1:0] address1;
    logic [DW-1:0] q1, out_data;
    logic          ce0 = 1'b0, we0 = 1'b0;
    logic [AW-1:0] address0 = '0;
    logic [DW-1:0] d0 = '0, q0;

    int total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    execute_upwards_mix_array_streamer #(.DataWidth(DW), .AddressWidth(AW), .AddressRange(AR)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .len(len), .busy(busy), .done(done),
        .address1(address1), .ce1(ce1), .q1(q1), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    execute_upwards_new_bro_node_mix_array_2 #(.DataWidth(DW), .AddressWidth(AW), .AddressRange(AR)) ram (
        .clk(clk), .address0(address0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0),
        .address1(address1), .ce1(ce1), .q1(q1)
    );

    typedef struct {
        int b;
        int l;
        int mode;      // 0: ready held high, 1: ready pattern 1,0,0 repeating
        int exp_done;  // expected done cycle relative to start, -1 = not timed
        bit glitch;    // pulse a second start mid-window
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic run_window(input int b, input int l, input int mode, input int exp_done, input bit glitch);
        int t0, rel, nce, npop, nvalid, done_rel;
        logic pstall, plast;
        logic [DW-1:0] pdata;
        nce = 0; npop = 0; nvalid = 0; done_rel = -1; pstall = 1'b0; plast = 1'b0; pdata = '0;
        @(negedge clk);
        start = 1'b1; base = AW'(b); len = (AW+1)'(l); out_ready = 1'b1;
        t0 = cyc;
        forever begin
            @(negedge clk);
            rel = cyc - t0;
            out_ready = (mode == 0) ? 1'b1 : ((rel % 3) == 0);
            start = glitch && (rel == 2);
            if (glitch && rel == 2) begin
                base = AW'(10);
                len  = (AW+1)'(2);
            end
            #1;
            if (rel == 1 && l > 0) chk("busy_c1", busy, 1);
            if (ce1) begin
                chk("addr", address1, (b + nce) % AR);
                nce++;
            end
            if (out_valid) nvalid++;
            if (pstall) begin
                chk("hold_data", out_data, pdata);
                chk("hold_last", out_last, plast);
            end
            if (out_valid && out_ready) begin
                chk("beat_data", out_data, ((b + npop) % AR) + 100);
                chk("beat_last", out_last, npop == l - 1);
                if (mode == 0) chk("beat_cycle", rel, 3 + npop);
                npop++;
            end
            chk("outstanding_le2", (nce - npop) <= 2, 1);
            pstall = out_valid && !out_ready;
            pdata  = out_data;
            plast  = out_last;
            if (done) begin
                chk("busy_at_done", busy, 0);
                done_rel = rel;
                break;
            end
            if (rel > 4 * l + 20) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
        out_ready = 1'b1;
        chk("n_issued", nce, l);
        chk("n_beats", npop, l);
        if (l == 0) chk("len0_no_valid", nvalid, 0);
        if (exp_done >= 0) chk("done_cycle", done_rel, exp_done);
    endtask

    initial begin
        int t0, npop, nd;
        vecs[0] = '{b: 0,  l: 4,  mode: 0, exp_done: 7,  glitch: 0};
        vecs[1] = '{b: 30, l: 4,  mode: 0, exp_done: 7,  glitch: 0};
        vecs[2] = '{b: 0,  l: 4,  mode: 1, exp_done: -1, glitch: 0};
        vecs[3] = '{b: 0,  l: 0,  mode: 0, exp_done: 1,  glitch: 0};
        vecs[4] = '{b: 5,  l: 32, mode: 0, exp_done: 35, glitch: 0};
        vecs[5] = '{b: 0,  l: 4,  mode: 0, exp_done: 7,  glitch: 1};
        vecs[6] = '{b: 31, l: 1,  mode: 0, exp_done: 4,  glitch: 0};
        vecs[7] = '{b: 7,  l: 3,  mode: 1, exp_done: -1, glitch: 0};

        // Preload through port 0 while the streamer is held in reset.
        for (int i = 0; i < AR; i++) begin
            @(negedge clk);
            ce0 = 1'b1; we0 = 1'b1; address0 = AW'(i); d0 = DW'(i + 100);
        end
        @(negedge clk);
        ce0 = 1'b0; we0 = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ce1", ce1, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_addr", address1, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b0;

        // Each window begins in the cycle right after the previous done.
        for (int v = 0; v < 8; v++)
            run_window(vecs[v].b, vecs[v].l, vecs[v].mode, vecs[v].exp_done, vecs[v].glitch);

        @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        // Reset after two beats of an 8-word window.
        @(negedge clk);
        start = 1'b1; base = '0; len = (AW+1)'(8); out_ready = 1'b1;
        t0 = cyc; npop = 0;
        for (int i = 0; i < 20 && npop < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (out_valid && out_ready) npop++;
        end
        chk("mid_beats", npop, 2);
        chk("mid_busy", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_ce1", ce1, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_last", out_last, 0);
        chk("mrst_addr", address1, 0);
        chk("mrst_data", out_data, 0);
        reset = 1'b0;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (done || out_valid || ce1) nd++;
        end
        chk("post_rst_quiet", nd, 0);
        run_window(3, 5, 0, 8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
